mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 4: cycles from request acceptance to earliest response pulse; legal range 2..16.
REQ-002 Parameter DEPTH, default 16: total request capacity, pipe plus response FIFO; power of two, 4..256.
REQ-003 Parameter STALL_SLACK, default 2: free entries remaining when rq_stall_out asserts; 1..DEPTH-1.
REQ-004 Parameter TAG_W, default 16: request/response tag width.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset; asserted when 0.
REQ-007 rq_vld_in  input  1  single-cycle request pulse, one request per high cycle.
REQ-008 rq_addr_in  input  48  request byte address.
REQ-009 rq_tag_in  input  TAG_W  request tag, returned unchanged.
REQ-010 rq_stall_out  output  1  registered; requester must stop issuing requests.
REQ-011 rs_vld_out  output  1  registered single-cycle response pulse.
REQ-012 rs_tag_out  output  TAG_W  tag of the response; valid while rs_vld_out=1.
REQ-013 rs_data_out  output  64  response data; valid while rs_vld_out=1.
REQ-014 rs_stall_in  input  1  consumer stall; no response issued in a cycle where it is sampled 1.
REQ-015 idle_out  output  1  registered; 1 when occupancy=0 and rs_vld_out=0.
REQ-016 overflow_out  output  1  sticky dropped-request flag.
REQ-017 rq_count_out  output  64  accepted-request count.
REQ-018 rs_count_out  output  64  issued-response count.

Function
REQ-019 Accepted request enters a LATENCY-1 stage delay pipe with no backpressure, then enters the response FIFO in order.
REQ-020 Occupancy = valid pipe stages + FIFO entries, range 0..DEPTH.
REQ-021 Request accepted when rq_vld_in=1 and occupancy<DEPTH at that edge; an occupancy=DEPTH request is dropped and overflow_out set, even if a response pops that cycle.
REQ-022 rq_stall_out=1 in the cycle after occupancy reaches >= DEPTH-STALL_SLACK; it deasserts in the cycle after occupancy falls below that.
REQ-023 Issue rule: FIFO non-empty and rs_stall_in=0 -> pop head; next cycle rs_vld_out=1 with its tag and data; otherwise rs_vld_out=0.
REQ-024 Request at edge t with no stall and empty FIFO -> rs_vld_out high in the cycle following edge t+LATENCY-1, i.e. exactly LATENCY cycles later.
REQ-025 Responses are strictly in request order; back-to-back requests yield back-to-back responses absent stall.
REQ-026 rs_data_out = {16'h0000, addr}; zero-extended.
REQ-027 Simultaneous push (pipe exit) and pop on the same edge: FIFO count unchanged, both honoured.
REQ-028 Accept and pop in the same cycle: occupancy unchanged.
REQ-029 rs_tag_out/rs_data_out hold their last value when rs_vld_out=0.
REQ-030 Counters are 64-bit and wrap modulo 2^64.

Reset
REQ-031 rst=0 asynchronously clears the pipe, the FIFO pointers and counts, and both counters.
REQ-032 During reset: rq_stall_out=0, rs_vld_out=0, rs_tag_out=0, rs_data_out=0, idle_out=1, overflow_out=0.
REQ-033 Reset mid-operation discards all in-flight requests; no response pulse for them after release.
REQ-034 First request is accepted on the first rising edge with rst=1.

Configuration
REQ-035 Macro MEM_RESPONDER_STATS_EN: if defined, rq_count_out increments on each accepted request and rs_count_out increments on each rs_vld_out pulse.
REQ-036 If undefined: the counter registers are not built, both ports are tied to 64'd0, and all other behaviour is identical.

Verification
REQ-037 Single request addr=48'h0000_1234_5678, tag=16'h00AB, LATENCY=4 -> one pulse 4 cycles later, tag 00AB, data 64'h0000_0000_1234_5678.
REQ-038 8 back-to-back requests, rs_stall_in=0 -> 8 contiguous pulses, tags in order, idle_out=1 one cycle after the last pulse.
REQ-039 rs_stall_in=1 held while 16 requests are issued with DEPTH=16 -> rq_stall_out high after occupancy reaches 14; 17th request dropped, overflow_out=1; release stall -> exactly 16 responses.
REQ-040 rst pulsed low while 5 requests are in flight -> no responses follow, idle_out=1, counters=0.
REQ-041 Same-cycle accept and pop with FIFO at DEPTH-1 -> no drop, order preserved.
REQ-042 Macro defined, 10 requests and 10 responses -> rq_count_out=10, rs_count_out=10; macro undefined -> both 0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory responder model.
// Each accepted request moves through a (LATENCY-1)-stage delay pipe and then
// into an in-order response FIFO. Total capacity (pipe + FIFO) is DEPTH.
// Responses carry the request tag and the zero-extended address as data.
// Optional feature macro: MEM_RESPONDER_STATS_EN builds the 64-bit
// request/response counters; without it both count ports read zero.
module mem_responder #(
    parameter int LATENCY     = 4,
    parameter int DEPTH       = 16,
    parameter int STALL_SLACK = 2,
    parameter int TAG_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rq_vld_in,
    input  logic [47:0]      rq_addr_in,
    input  logic [TAG_W-1:0] rq_tag_in,
    output logic             rq_stall_out,
    output logic             rs_vld_out,
    output logic [TAG_W-1:0] rs_tag_out,
    output logic [63:0]      rs_data_out,
    input  logic             rs_stall_in,
    output logic             idle_out,
    output logic             overflow_out,
    output logic [63:0]      rq_count_out,
    output logic [63:0]      rs_count_out
);

    localparam int STG   = LATENCY - 1;
    localparam int LAST  = STG - 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_OCC  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_THR = CNT_W'(DEPTH - STALL_SLACK);

    // Delay pipe: valid is reset, payload is not
    logic             pipe_vld_p  [STG];
    logic [TAG_W-1:0] pipe_tag_p  [STG];
    logic [47:0]      pipe_addr_p [STG];

    // Response FIFO storage
    logic [TAG_W-1:0] fifo_tag  [DEPTH];
    logic [47:0]      fifo_addr [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;

    // Occupancy = valid pipe stages + FIFO entries
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] occ_nxt;

    logic             accept;
    logic             drop;
    logic             exit_vld;
    logic             fifo_empty;
    logic             issue;
    logic             bypass;
    logic             fifo_push;
    logic             fifo_pop;
    logic [TAG_W-1:0] head_tag;
    logic [47:0]      head_addr;

    // Accept/issue decisions; the pipe exit feeds the output directly when the
    // FIFO is empty so an unstalled request sees exactly LATENCY cycles.
    always_comb begin
        accept     = rq_vld_in && (occ < FULL_OCC);
        drop       = rq_vld_in && !accept;
        exit_vld   = pipe_vld_p[LAST];
        fifo_empty = (fifo_cnt == '0);
        issue      = !rs_stall_in && (!fifo_empty || exit_vld);
        bypass     = issue && fifo_empty;
        fifo_pop   = issue && !fifo_empty;
        fifo_push  = exit_vld && !bypass;
        head_tag   = fifo_empty ? pipe_tag_p[LAST]  : fifo_tag[rd_ptr];
        head_addr  = fifo_empty ? pipe_addr_p[LAST] : fifo_addr[rd_ptr];
        occ_nxt    = occ;
        if (accept && !issue) begin
            occ_nxt = occ + CNT_W'(1);
        end else if (!accept && issue) begin
            occ_nxt = occ - CNT_W'(1);
        end
    end

    // Pipe valid bits shift every cycle; no backpressure inside the pipe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STG; i++) begin
                pipe_vld_p[i] <= 1'b0;
            end
        end else begin
            pipe_vld_p[0] <= accept;
            for (int i = 1; i < STG; i++) begin
                pipe_vld_p[i] <= pipe_vld_p[i-1];
            end
        end
    end

    // Pipe payload follows the valid bits
    always_ff @(posedge clk) begin
        pipe_tag_p[0]  <= rq_tag_in;
        pipe_addr_p[0] <= rq_addr_in;
        for (int i = 1; i < STG; i++) begin
            pipe_tag_p[i]  <= pipe_tag_p[i-1];
            pipe_addr_p[i] <= pipe_addr_p[i-1];
        end
    end

    // FIFO storage write at the pipe exit
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_tag[wr_ptr]  <= pipe_tag_p[LAST];
            fifo_addr[wr_ptr] <= pipe_addr_p[LAST];
        end
    end

    // FIFO pointers, fill count and total occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            occ      <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (fifo_push && !fifo_pop) begin
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            end else if (fifo_pop && !fifo_push) begin
                fifo_cnt <= fifo_cnt - CNT_W'(1);
            end
            occ <= occ_nxt;
        end
    end

    // Registered status: stall follows occupancy by one cycle, idle reflects
    // the state being entered, overflow is sticky
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rq_stall_out <= 1'b0;
            idle_out     <= 1'b1;
            overflow_out <= 1'b0;
            rs_vld_out   <= 1'b0;
        end else begin
            rq_stall_out <= (occ >= STALL_THR);
            idle_out     <= (occ_nxt == '0) && !issue;
            overflow_out <= overflow_out || drop;
            rs_vld_out   <= issue;
        end
    end

    // Response payload loads on issue and otherwise holds
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs_tag_out  <= '0;
            rs_data_out <= '0;
        end else if (issue) begin
            rs_tag_out  <= head_tag;
            rs_data_out <= {16'h0000, head_addr};
        end
    end

`ifdef MEM_RESPONDER_STATS_EN
    logic [63:0] rq_cnt;
    logic [63:0] rs_cnt;

    // Free-running wrap-around request/response counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rq_cnt <= '0;
            rs_cnt <= '0;
        end else begin
            if (accept) begin
                rq_cnt <= rq_cnt + 64'd1;
            end
            if (issue) begin
                rs_cnt <= rs_cnt + 64'd1;
            end
        end
    end

    assign rq_count_out = rq_cnt;
    assign rs_count_out = rs_cnt;
`else
    assign rq_count_out = 64'd0;
    assign rs_count_out = 64'd0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: randomized stimulus against a timestamped
// in-order queue model of the responder.
module tb_mem_responder;

    localparam int LAT = 4;
    localparam int DEP = 16;
    localparam int SLK = 2;
    localparam int TW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rq_vld_in;
    logic [47:0]   rq_addr_in;
    logic [TW-1:0] rq_tag_in;
    logic          rq_stall_out;
    logic          rs_vld_out;
    logic [TW-1:0] rs_tag_out;
    logic [63:0]   rs_data_out;
    logic          rs_stall_in;
    logic          idle_out;
    logic          overflow_out;
    logic [63:0]   rq_count_out;
    logic [63:0]   rs_count_out;

    mem_responder #(.LATENCY(LAT), .DEPTH(DEP), .STALL_SLACK(SLK), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .rq_vld_in(rq_vld_in), .rq_addr_in(rq_addr_in), .rq_tag_in(rq_tag_in),
        .rq_stall_out(rq_stall_out),
        .rs_vld_out(rs_vld_out), .rs_tag_out(rs_tag_out), .rs_data_out(rs_data_out),
        .rs_stall_in(rs_stall_in), .idle_out(idle_out), .overflow_out(overflow_out),
        .rq_count_out(rq_count_out), .rs_count_out(rs_count_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: requests waiting to respond, each stamped with the
    // first edge at which it may be issued (accept edge + LATENCY-1).
    typedef struct {
        logic [TW-1:0] tag;
        logic [47:0]   addr;
        int            rdy;
    } item_t;

    item_t         q[$];
    int            cyc = 0;
    logic          m_vld, m_stall, m_idle, m_ovf;
    logic [TW-1:0] m_tag;
    logic [63:0]   m_data;
    longint        m_rq, m_rs;

    function automatic void model_clear();
        q.delete();
        m_vld = 0; m_stall = 0; m_idle = 1; m_ovf = 0;
        m_tag = '0; m_data = '0; m_rq = 0; m_rs = 0;
    endfunction

    function automatic logic [63:0] exp_cnt(longint v);
`ifdef MEM_RESPONDER_STATS_EN
        return 64'(v);
`else
        return 64'd0;
`endif
    endfunction

    // One clock edge: advance the model with the inputs seen at that edge
    task automatic tick();
        int   sz;
        item_t it;
        @(posedge clk);
        if (!rst) begin
            model_clear();
        end else begin
            sz      = q.size();
            m_stall = (sz >= DEP - SLK);
            m_vld   = 0;
            if (!rs_stall_in && sz > 0 && q[0].rdy <= cyc) begin
                it     = q.pop_front();
                m_vld  = 1;
                m_tag  = it.tag;
                m_data = {16'h0000, it.addr};
                m_rs++;
            end
            if (rq_vld_in) begin
                if (sz < DEP) begin
                    it.tag = rq_tag_in; it.addr = rq_addr_in; it.rdy = cyc + LAT - 1;
                    q.push_back(it);
                    m_rq++;
                end else begin
                    m_ovf = 1;
                end
            end
            m_idle = (q.size() == 0) && !m_vld;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 0; rq_vld_in = 0; rs_stall_in = 0;
        model_clear();
        tick(); tick();
        rst = 1;
    endtask

    task automatic rand_req();
        rq_vld_in  = 1;
        rq_addr_in = {16'($urandom()), $urandom()};
        rq_tag_in  = TW'($urandom());
    endtask

    task automatic test_reset();
        rst = 0; rq_vld_in = 0; rs_stall_in = 0; rq_addr_in = '0; rq_tag_in = '0;
        model_clear();
        #2;
        tick(); tick();
        checks++; if (rq_stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", rq_stall_out); end
        checks++; if (rs_vld_out !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", rs_vld_out); end
        checks++; if (rs_tag_out !== '0) begin errors++; $display("FAIL reset_tag got %h want 0", rs_tag_out); end
        checks++; if (rs_data_out !== 64'd0) begin errors++; $display("FAIL reset_data got %h want 0", rs_data_out); end
        checks++; if (idle_out !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle_out); end
        checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow_out); end
        checks++; if (rq_count_out !== 64'd0 || rs_count_out !== 64'd0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", rq_count_out, rs_count_out); end
        rst = 1;
    endtask

    task automatic test_single();
        do_reset();
        rq_vld_in = 1; rq_addr_in = 48'h0000_1234_5678; rq_tag_in = 16'h00AB;
        tick();
        rq_vld_in = 0;
        for (int k = 1; k <= LAT + 3; k++) begin
            tick();
            checks++;
            if (rs_vld_out !== (k == LAT - 1)) begin
                errors++; $display("FAIL single_vld k=%0d got %b want %b", k, rs_vld_out, (k == LAT - 1));
            end
            if (k == LAT - 1) begin
                checks++; if (rs_tag_out !== 16'h00AB) begin errors++; $display("FAIL single_tag got %h want 00ab", rs_tag_out); end
                checks++; if (rs_data_out !== 64'h0000_0000_1234_5678) begin
                    errors++; $display("FAIL single_data got %h want 0000000012345678", rs_data_out); end
            end
        end
        checks++; if (idle_out !== 1'b1) begin errors++; $display("FAIL single_idle got %b want 1", idle_out); end
    endtask

    task automatic test_back_to_back();
        logic [TW-1:0] tags[$];
        int first = -1, last = -1, n = 0;
        logic prev = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rand_req(); tags.push_back(rq_tag_in);
            tick();
            if (rs_vld_out) begin if (first < 0) first = i; last = i; n++; end
            prev = rs_vld_out;
        end
        rq_vld_in = 0;
        for (int i = 8; i < 30; i++) begin
            tick();
            if (rs_vld_out) begin
                if (first < 0) first = i;
                last = i; n++;
                checks++; if (rs_tag_out !== tags[n-1]) begin
                    errors++; $display("FAIL b2b_tag #%0d got %h want %h", n, rs_tag_out, tags[n-1]); end
            end else if (prev) begin
                checks++; if (idle_out !== 1'b1) begin errors++; $display("FAIL b2b_idle got %b want 1", idle_out); end
            end
            prev = rs_vld_out;
        end
        checks++; if (n != 8 || last - first != 7) begin
            errors++; $display("FAIL b2b_contig got %0d pulses span %0d want 8 span 7", n, last - first); end
    endtask

    task automatic test_overflow();
        int n = 0;
        do_reset();
        rs_stall_in = 1;
        for (int i = 1; i <= 17; i++) begin
            rand_req();
            tick();
            checks++; if (rq_stall_out !== m_stall) begin
                errors++; $display("FAIL ovf_stall req %0d got %b want %b", i, rq_stall_out, m_stall); end
            if (i == 16) begin
                checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow_out); end
            end
        end
        rq_vld_in = 0;
        tick();
        checks++; if (overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow_out); end
        checks++; if (rq_stall_out !== 1'b1) begin errors++; $display("FAIL ovf_stall_hold got %b want 1", rq_stall_out); end
        rs_stall_in = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rs_vld_out) n++;
            checks++; if (rs_vld_out !== m_vld || rs_tag_out !== m_tag || rq_stall_out !== m_stall) begin
                errors++; $display("FAIL ovf_drain cyc %0d got vld %b tag %h stall %b want %b %h %b",
                                   i, rs_vld_out, rs_tag_out, rq_stall_out, m_vld, m_tag, m_stall); end
        end
        checks++; if (n != 16) begin errors++; $display("FAIL ovf_count got %0d want 16", n); end
    endtask

    task automatic test_same_cycle();
        logic [TW-1:0] tags[$];
        int n = 0;
        do_reset();
        rs_stall_in = 1;
        for (int i = 0; i < DEP - 1; i++) begin rand_req(); tags.push_back(rq_tag_in); tick(); end
        rq_vld_in = 0;
        repeat (LAT) tick();
        rs_stall_in = 0;
        for (int i = 0; i < 6; i++) begin
            rand_req(); tags.push_back(rq_tag_in);
            tick();
            if (rs_vld_out) begin
                n++;
                checks++; if (rs_tag_out !== tags[n-1]) begin
                    errors++; $display("FAIL same_tag #%0d got %h want %h", n, rs_tag_out, tags[n-1]); end
            end
        end
        rq_vld_in = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rs_vld_out) begin
                n++;
                checks++; if (rs_tag_out !== tags[n-1]) begin
                    errors++; $display("FAIL same_tag #%0d got %h want %h", n, rs_tag_out, tags[n-1]); end
            end
        end
        checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL same_ovf got %b want 0", overflow_out); end
        checks++; if (n != DEP - 1 + 6) begin errors++; $display("FAIL same_count got %0d want %0d", n, DEP + 5); end
    endtask

    task automatic test_reset_midflight();
        int bad = 0;
        do_reset();
        rs_stall_in = 1;
        for (int i = 0; i < 5; i++) begin rand_req(); tick(); end
        rq_vld_in = 0;
        rst = 0;
        model_clear();
        #2;
        checks++; if (rs_vld_out !== 1'b0 || idle_out !== 1'b1 || rq_stall_out !== 1'b0) begin
            errors++; $display("FAIL mid_async got vld %b idle %b stall %b want 0 1 0", rs_vld_out, idle_out, rq_stall_out); end
        tick(); tick();
        rst = 1; rs_stall_in = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rs_vld_out !== 1'b0 || idle_out !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_quiet got %0d bad cycles want 0", bad); end
        checks++; if (rq_count_out !== 64'd0 || rs_count_out !== 64'd0) begin
            errors++; $display("FAIL mid_cnt got %0d/%0d want 0/0", rq_count_out, rs_count_out); end
    endtask

    task automatic test_counters();
        do_reset();
        for (int i = 0; i < 10; i++) begin rand_req(); tick(); end
        rq_vld_in = 0;
        repeat (20) tick();
        checks++; if (rq_count_out !== exp_cnt(10)) begin
            errors++; $display("FAIL cnt_rq got %0d want %0d", rq_count_out, exp_cnt(10)); end
        checks++; if (rs_count_out !== exp_cnt(10)) begin
            errors++; $display("FAIL cnt_rs got %0d want %0d", rs_count_out, exp_cnt(10)); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 55) rand_req(); else rq_vld_in = 0;
            rs_stall_in = ($urandom_range(99) < ((i / 150) % 2 ? 60 : 20));
            tick();
            checks++;
            if (rs_vld_out !== m_vld || rs_tag_out !== m_tag || rs_data_out !== m_data ||
                rq_stall_out !== m_stall || idle_out !== m_idle || overflow_out !== m_ovf) begin
                errors++;
                $display("FAIL rand cyc %0d got vld %b tag %h data %h stall %b idle %b ovf %b want %b %h %h %b %b %b",
                         i, rs_vld_out, rs_tag_out, rs_data_out, rq_stall_out, idle_out, overflow_out,
                         m_vld, m_tag, m_data, m_stall, m_idle, m_ovf);
            end
        end
        checks++; if (rq_count_out !== exp_cnt(m_rq) || rs_count_out !== exp_cnt(m_rs)) begin
            errors++; $display("FAIL rand_cnt got %0d/%0d want %0d/%0d", rq_count_out, rs_count_out,
                               exp_cnt(m_rq), exp_cnt(m_rs)); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_same_cycle();
        test_reset_midflight();
        test_counters();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
